volume_request_arbiter: RTL

- Shares one block-device transfer engine between the two drive volumes.
- Each volume posts level rd/wr requests with an lba and blk_cnt, using a 4-phase req/ack handshake.
- The arbiter picks one request round-robin, checks that it is legal, issues it to the engine and waits for completion.
- It then acks the requesting volume and releases the engine once the volume drops its request.
- It sits between the volume-side request lines and the storage engine, and is sequenced by PicoSoC firmware.

---
 rtl/a2disk_pkg.sv | 22 ++
 rtl/rr_arbiter2.sv | 27 ++
 rtl/volume_request_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/a2disk_pkg.sv
// Shared types and sizes for the two-volume block request path.
package a2disk_pkg;

  localparam int NUM_VOLUMES = 2;
  localparam int BLK_CNT_W   = 6;
  localparam int LBA_W       = 32;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ISSUE,
    WAIT,
    ACK
  } state_t;

  typedef struct packed {
    logic                 write;
    logic [LBA_W-1:0]     lba;
    logic [BLK_CNT_W-1:0] blk_cnt;
  } vol_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin: combinational grant, registered last-granted pointer.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  logic last_q;

  // On a tie the volume not served last wins.
  always_comb begin
    gnt_valid = |req;
    gnt_idx   = (&req) ? ~last_q : req[1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (take && gnt_valid) begin
      last_q <= gnt_idx;
    end
  end

endmodule

// File: rtl/volume_request_arbiter.sv
// Shares one block transfer engine between two volumes: round-robin grant,
// legality check, engine issue, completion wait and 4-phase ack.
module volume_request_arbiter
  import a2disk_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_W          = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_VOLUMES-1:0] vol_mounted,
  input  logic [NUM_VOLUMES-1:0] vol_readonly,
  input  logic [NUM_VOLUMES-1:0] vol_rd,
  input  logic [NUM_VOLUMES-1:0] vol_wr,
  input  logic [63:0]            vol_lba,
  input  logic [11:0]            vol_blk_cnt,
  output logic [NUM_VOLUMES-1:0] vol_ack,
  output logic [NUM_VOLUMES-1:0] vol_err,
  output logic                   dev_req_valid,
  input  logic                   dev_req_ready,
  output logic                   dev_req_write,
  output logic [LBA_W-1:0]       dev_req_lba,
  output logic [BLK_CNT_W-1:0]   dev_req_blk_cnt,
  output logic                   dev_req_vol,
  input  logic                   dev_done,
  input  logic                   dev_error,
  output logic                   busy,
  output logic                   grant
);

  localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t               state;
  vol_req_t             req_q;
  logic                 vol_q;
  logic                 both_q;
  logic [CNT_W-1:0]     cnt_q;

  logic [1:0]           pending;
  logic                 gnt_valid;
  logic                 gnt_idx;
  logic [LBA_W-1:0]     sel_lba;
  logic [BLK_CNT_W-1:0] sel_cnt;
  logic                 reject;

  assign pending = (vol_rd | vol_wr) & ~vol_ack;
  assign sel_lba = gnt_idx ? vol_lba[63:32] : vol_lba[31:0];
  assign sel_cnt = gnt_idx ? vol_blk_cnt[11:6] : vol_blk_cnt[5:0];

  rr_arbiter2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (pending),
    .take      (state == IDLE),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Legality is judged on the latched request; mount and write-protect are live config.
  assign reject = ~vol_mounted[vol_q]
                | both_q
                | (req_q.write & vol_readonly[vol_q])
                | (req_q.blk_cnt == '0);

  assign dev_req_write   = req_q.write;
  assign dev_req_lba     = req_q.lba;
  assign dev_req_blk_cnt = req_q.blk_cnt;
  assign dev_req_vol     = vol_q;
  assign busy            = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      req_q         <= '0;
      vol_q         <= 1'b0;
      both_q        <= 1'b0;
      grant         <= 1'b0;
      dev_req_valid <= 1'b0;
      vol_ack       <= '0;
      vol_err       <= '0;
      cnt_q         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            vol_q         <= gnt_idx;
            grant         <= gnt_idx;
            req_q.write   <= vol_wr[gnt_idx];
            req_q.lba     <= sel_lba;
            req_q.blk_cnt <= sel_cnt;
            both_q        <= vol_rd[gnt_idx] & vol_wr[gnt_idx];
            state         <= CHECK;
          end
        end
        CHECK: begin
          if (reject) begin
            vol_ack[vol_q] <= 1'b1;
            vol_err[vol_q] <= 1'b1;
            state          <= ACK;
          end else begin
            dev_req_valid <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (dev_req_ready) begin
            dev_req_valid <= 1'b0;
            cnt_q         <= '0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          // A completion in the timeout cycle takes priority over the abort.
          if (dev_done) begin
            vol_ack[vol_q] <= 1'b1;
            vol_err[vol_q] <= dev_error;
            state          <= ACK;
          end else if (TO_EN && (cnt_q == TO_LAST)) begin
            vol_ack[vol_q] <= 1'b1;
            vol_err[vol_q] <= 1'b1;
            state          <= ACK;
          end
        end
        ACK: begin
          if (!vol_rd[vol_q] && !vol_wr[vol_q]) begin
            vol_ack <= '0;
            vol_err <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
